// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM between the VGA
// scan-out reader (absolute priority) and a host pixel-writer whose requests
// are queued in a small in-order FIFO and issued in slots video leaves free.
//
// Optional feature: define FB_ARB_HOST_READ_EN to enable host reads. When it
// is undefined, host reads complete the handshake but are discarded, and
// host_rvalid/host_q are tied to 0.
//
// Ports:
//   CLOCK_50, reset       clock, synchronous active-low reset
//   vid_req/vid_adr       video read request (always accepted)
//   vid_valid/vid_q       video read result, 2 cycles after the request
//   host_valid/host_ready host request handshake
//   host_we/adr/d         host request payload
//   host_rvalid/host_q    host read result
//   fifo_level            host FIFO occupancy (0..DEPTH)
//   ram_adr/ram_d/ram_we  registered RAM controls
//   ram_q                 RAM read data for the address currently on ram_adr
module fb_port_arbiter #(
    parameter int unsigned DW    = 24,
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     vid_req,
    input  logic [AW-1:0]            vid_adr,
    output logic                     vid_valid,
    output logic [DW-1:0]            vid_q,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     host_we,
    input  logic [AW-1:0]            host_adr,
    input  logic [DW-1:0]            host_d,
    output logic                     host_rvalid,
    output logic [DW-1:0]            host_q,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [AW-1:0]            ram_adr,
    output logic [DW-1:0]            ram_d,
    output logic                     ram_we,
    input  logic [DW-1:0]            ram_q
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            vid_t1;

    logic            push_c;
    logic            pop_c;
    logic [LW-1:0]   level_nxt_c;
    entry_t          head_c;

    // Handshake, slot choice and next occupancy
    always_comb begin
        push_c      = 1'b0;
        pop_c       = 1'b0;
        level_nxt_c = fifo_level;
        head_c      = fifo_mem[rd_ptr];
`ifdef FB_ARB_HOST_READ_EN
        push_c      = host_valid & host_ready;
`else
        // Reads are acknowledged but never stored
        push_c      = host_valid & host_ready & host_we;
`endif
        // Video owns the slot whenever it asks; the FIFO only drains otherwise
        pop_c       = ~vid_req & (fifo_level != LW'(0));
        level_nxt_c = fifo_level + LW'(push_c) - LW'(pop_c);
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge CLOCK_50) begin
        if (reset && push_c) begin
            fifo_mem[wr_ptr] <= '{we: host_we, adr: host_adr, d: host_d};
        end
    end

    // Pointers, RAM controls and the tag pipeline
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            host_ready <= 1'b0;
            ram_adr    <= '0;
            ram_d      <= '0;
            ram_we     <= 1'b0;
            vid_t1     <= 1'b0;
            vid_valid  <= 1'b0;
            vid_q      <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= level_nxt_c;
            // A full FIFO refuses a push even when a pop frees space this cycle
            host_ready <= (level_nxt_c < LW'(DEPTH));

            if (vid_req) begin
                ram_adr <= vid_adr;
                ram_we  <= 1'b0;
            end else if (pop_c) begin
                ram_adr <= head_c.adr;
                ram_we  <= head_c.we;
                if (head_c.we) begin
                    ram_d <= head_c.d;
                end
            end else begin
                ram_we  <= 1'b0;
            end

            vid_t1    <= vid_req;
            vid_valid <= vid_t1;
            if (vid_t1) begin
                vid_q <= ram_q;
            end
        end
    end

`ifdef FB_ARB_HOST_READ_EN
    logic hrd_t1;

    // Host read tag stage
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            hrd_t1      <= 1'b0;
            host_rvalid <= 1'b0;
            host_q      <= '0;
        end else begin
            hrd_t1      <= pop_c & ~head_c.we;
            host_rvalid <= hrd_t1;
            if (hrd_t1) begin
                host_q <= ram_q;
            end
        end
    end
`else
    assign host_rvalid = 1'b0;
    assign host_q      = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a queue-based reference model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_fb_port_arbiter;

    localparam int unsigned DW    = 24;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;
`ifdef FB_ARB_HOST_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_adr;
    logic          vid_valid;
    logic [DW-1:0] vid_q;
    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_adr;
    logic [DW-1:0] host_d;
    logic          host_rvalid;
    logic [DW-1:0] host_q;
    logic [LW-1:0] fifo_level;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    always #10 CLOCK_50 = ~CLOCK_50;

    fb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_adr    (vid_adr),
        .vid_valid  (vid_valid),
        .vid_q      (vid_q),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_we    (host_we),
        .host_adr   (host_adr),
        .host_d     (host_d),
        .host_rvalid(host_rvalid),
        .host_q     (host_q),
        .fifo_level (fifo_level),
        .ram_adr    (ram_adr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    // Bench RAM: 32 words, read of the registered address, write at the edge
    logic [DW-1:0] ram [0:31];
    logic          pre_we;
    logic [4:0]    pre_adr;
    logic [DW-1:0] pre_d;
    assign ram_q = ram[ram_adr[4:0]];
    always @(posedge CLOCK_50) begin
        if (pre_we) ram[pre_adr] <= pre_d;
        else if (ram_we) ram[ram_adr[4:0]] <= ram_d;
    end

    // Reference model
    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mm [0:31];
    logic          exp_ram_we, exp_vid_valid, exp_host_rvalid, exp_ready;
    logic [AW-1:0] exp_ram_adr;
    logic [DW-1:0] exp_ram_d, exp_vid_q, exp_host_q;
    int            exp_level;
    logic          p_vid, p_hrd;
    logic [DW-1:0] p_vdata, p_hdata;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the abstract behaviour: results land two edges after
    // the slot that issued them; the FIFO is a plain in-order queue.
    task automatic model_step();
        ent_t h;
        bit   acc;
        if (!reset) begin
            q.delete();
            exp_ram_we = 0; exp_ram_adr = '0; exp_ram_d = '0;
            exp_vid_valid = 0; exp_vid_q = '0;
            exp_host_rvalid = 0; exp_host_q = '0;
            p_vid = 0; p_hrd = 0; p_vdata = '0; p_hdata = '0;
            exp_ready = 0;
        end else begin
            acc = host_valid && exp_ready;
            exp_vid_valid   = p_vid;
            exp_host_rvalid = p_hrd;
            if (p_vid) exp_vid_q  = p_vdata;
            if (p_hrd) exp_host_q = p_hdata;
            p_vid = 0;
            p_hrd = 0;
            if (vid_req) begin
                exp_ram_adr = vid_adr;
                exp_ram_we  = 0;
                p_vid       = 1;
                p_vdata     = mm[vid_adr[4:0]];
            end else if (q.size() > 0) begin
                h = q.pop_front();
                exp_ram_adr = h.adr;
                exp_ram_we  = h.we;
                if (h.we) begin
                    exp_ram_d      = h.d;
                    mm[h.adr[4:0]] = h.d;
                end else begin
                    p_hrd   = 1;
                    p_hdata = mm[h.adr[4:0]];
                end
            end else begin
                exp_ram_we = 0;
            end
            if (acc && (host_we || READ_EN)) q.push_back('{we: host_we, adr: host_adr, d: host_d});
            exp_ready = (q.size() < DEPTH);
        end
        exp_level = q.size();
    endtask

    task automatic compare_all();
        chk("ram_we", 32'(ram_we), 32'(exp_ram_we));
        chk("ram_adr", 32'(ram_adr), 32'(exp_ram_adr));
        chk("ram_d", 32'(ram_d), 32'(exp_ram_d));
        chk("vid_valid", 32'(vid_valid), 32'(exp_vid_valid));
        chk("vid_q", 32'(vid_q), 32'(exp_vid_q));
        chk("host_rvalid", 32'(host_rvalid), 32'(exp_host_rvalid));
        chk("host_q", 32'(host_q), 32'(exp_host_q));
        chk("fifo_level", 32'(fifo_level), 32'(exp_level));
        chk("host_ready", 32'(host_ready), 32'(exp_ready));
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        compare_all();
    endtask

    task automatic idle_inputs();
        vid_req = 0; vid_adr = '0;
        host_valid = 0; host_we = 0; host_adr = '0; host_d = '0;
    endtask

    initial begin
        int k;
        bit acc;
        logic [DW-1:0] v;
        reset = 0; pre_we = 0; pre_adr = '0; pre_d = '0;
        idle_inputs();

        // Reset while preloading the RAM and the model memory alike
        for (int i = 0; i < 32; i++) begin
            v = (i == 16) ? 24'h123456 : DW'(i * 24'h010203);
            pre_we = 1; pre_adr = 5'(i); pre_d = v;
            mm[i] = v;
            step();
        end
        pre_we = 0;
        step();
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);

        reset = 1;
        step();
        chk("post_rst_host_ready", 32'(host_ready), 32'd1);
        chk("post_rst_vid_valid", 32'(vid_valid), 32'd0);
        for (int i = 0; i < 6; i++) step();

        // Single video read of 0x0010
        vid_req = 1; vid_adr = 16'h0010;
        step();
        vid_req = 0;
        chk("vid_lat_n1_valid", 32'(vid_valid), 32'd0);
        step();
        chk("vid_lat_n2_valid", 32'(vid_valid), 32'd1);
        chk("vid_lat_n2_q", 32'(vid_q), 32'h123456);
        step();
        chk("vid_lat_n3_valid", 32'(vid_valid), 32'd0);

        // Video burst of 8 with five host writes offered
        k = 0;
        vid_req = 1;
        for (int i = 0; i < 8; i++) begin
            vid_adr = 16'(i);
            if (k < 5) begin
                host_valid = 1; host_we = 1; host_adr = 16'(20 + k); host_d = DW'(24'hA00000 + k);
            end else begin
                host_valid = 0;
            end
            acc = host_ready;
            step();
            if (acc && k < 5) k++;
            chk("burst_no_we", 32'(ram_we), 32'd0);
        end
        chk("burst_accepted", 32'(k), 32'd4);
        chk("burst_level", 32'(fifo_level), 32'd4);
        chk("burst_ready", 32'(host_ready), 32'd0);
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            step();
            chk("drain_we", 32'(ram_we), 32'd1);
            chk("drain_adr", 32'(ram_adr), 32'(20 + j));
            chk("drain_d", 32'(ram_d), 32'(24'hA00000 + j));
        end
        chk("drain_ready", 32'(host_ready), 32'd1);
        step();
        step();

        // Alternating video with a queued write to 0x0005
        vid_req = 1; vid_adr = 16'h0001;
        host_valid = 1; host_we = 1; host_adr = 16'h0005; host_d = 24'hABCDEF;
        step();
        idle_inputs();
        step();
        chk("alt_we", 32'(ram_we), 32'd1);
        chk("alt_adr", 32'(ram_adr), 32'h0005);
        chk("alt_d", 32'(ram_d), 32'hABCDEF);
        vid_req = 1; vid_adr = 16'h0005;
        step();
        vid_req = 0;
        step();
        chk("alt_rd_valid", 32'(vid_valid), 32'd1);
        chk("alt_rd_q", 32'(vid_q), 32'hABCDEF);
        step();

        // Host write then host read of 0x0007
        host_valid = 1; host_we = 1; host_adr = 16'h0007; host_d = 24'h00FF00;
        step();
        host_we = 0; host_d = '0;
        step();
        idle_inputs();
        chk("hrd_level", 32'(fifo_level), 32'(READ_EN));
        step();
        chk("hrd_n3_rvalid", 32'(host_rvalid), 32'd0);
        step();
        chk("hrd_rvalid", 32'(host_rvalid), 32'(READ_EN));
        chk("hrd_q", 32'(host_q), READ_EN ? 32'h00FF00 : 32'h0);
        step();

        // Reset with three queued writes and a video read in flight
        vid_req = 1;
        for (int i = 0; i < 3; i++) begin
            vid_adr = 16'(i);
            host_valid = 1; host_we = 1; host_adr = 16'(8 + i); host_d = DW'(24'h5A0000 + i);
            step();
        end
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        idle_inputs();
        reset = 0;
        step();
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        chk("mid_rst_vid_valid", 32'(vid_valid), 32'd0);
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after_rst_we", 32'(ram_we), 32'd0);
            chk("after_rst_vid_valid", 32'(vid_valid), 32'd0);
        end

        // Randomized traffic on a small address window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 399) != 0);
            vid_req    = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 50 : 80));
            vid_adr    = 16'($urandom_range(0, 31));
            host_valid = ($urandom_range(0, 99) < 60);
            host_we    = ($urandom_range(0, 99) < 55);
            host_adr   = 16'($urandom_range(0, 31));
            host_d     = DW'($urandom);
            step();
        end
        reset = 1;
        idle_inputs();
        for (int i = 0; i < 8; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port 24-bit framebuffer RAM between the VGA scan-out reader and a host pixel-writer. Video reads have absolute priority. Host requests are buffered in a small FIFO and issued in any CLOCK_50 cycle that video leaves free. It sits between the framebuffer RAM instance and its two clients, and owns the RAM's address, data and write-enable pins.

## Interface
- DW, 24: RAM data width (RGB888).
- AW, 16: RAM address width.
- DEPTH, 4: host FIFO entries; power of two, minimum 2.
- CLOCK_50  in  1  system clock; every RAM access is one CLOCK_50 cycle.
- reset  in  1  reset, synchronous, active-low.
- vid_req  in  1  video read request, one per cycle, no handshake, always accepted.
- vid_adr  in  AW  video read address, sampled when vid_req=1.
- vid_valid  out  1  vid_q holds data for the request made 2 cycles earlier.
- vid_q  out  DW  video read data.
- host_valid  in  1  host request offered.
- host_ready  out  1  FIFO can accept; a transfer happens when host_valid & host_ready.
- host_we  in  1  1 = write, 0 = read.
- host_adr  in  AW  host address.
- host_d  in  DW  host write data.
- host_rvalid  out  1  host read data valid.
- host_q  out  DW  host read data.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ram_adr  out  AW  registered RAM address.
- ram_d  out  DW  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_q  in  DW  RAM read data, valid 1 cycle after ram_adr.

## Operation
- Slot decision each cycle:
  - vid_req=1 → video slot.
  - Otherwise, FIFO non-empty → host slot; pop the head entry.
  - Otherwise → idle slot.
- Video slot: ram_adr<=vid_adr, ram_we<=0.
- Host write slot: ram_adr/ram_d <= entry, ram_we<=1.
- Host read slot: ram_adr<=entry address, ram_we<=0.
- Idle slot: ram_we<=0, ram_adr holds its value.
- Tag pipeline: a 2-stage shift of {vid, hrd} tags follows each slot. At stage 2, ram_q is registered into vid_q or host_q, and vid_valid or host_rvalid pulses for one cycle.
- FIFO: stores {we, adr, d}, strictly in order.
  - host_ready = (fifo_level < DEPTH), computed from registered state. A push is refused when full even if a pop happens in the same cycle.
  - Push and pop in the same cycle leaves the level unchanged.
  - No bypass: a push into an empty FIFO is issued in the next cycle at the earliest.
- Host read-after-write to the same address returns the new data, because entries are issued in order.
- Starvation: host entries wait indefinitely while vid_req stays high. Scan-out uses at most 50% of slots, so the system guarantees progress.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_level is the count, 0..DEPTH.

## Timing
- Reset values (reset=0 sampled on a CLOCK_50 edge): ram_we=0, ram_adr=0, ram_d=0, vid_valid=0, vid_q=0, host_rvalid=0, host_q=0, fifo_level=0, host_ready=0 during reset and 1 in the first cycle after release.
- Reset mid-operation: FIFO flushed, in-flight tags dropped, no valid pulse from pre-reset requests, ram_we deasserted in the next cycle.
- Video latency: vid_req in cycle N → ram_adr in N+1 → vid_valid/vid_q in N+2. Back-to-back requests stream one result per cycle.
- Host write: accepted in cycle N into an empty FIFO, with no video → ram_we=1 in cycle N+2.
- Host read: accepted in cycle N, with no video → host_rvalid in cycle N+3.

## Configuration
- FB_ARB_HOST_READ_EN defined: host reads are enqueued and serviced as above.
- Undefined:
  - host_rvalid and host_q are tied to 0.
  - Any transfer with host_we=0 completes the handshake but is discarded, not enqueued.
  - The hrd tag stage is removed.

## Test plan
- Reset release, idle inputs → all outputs 0, host_ready=1 from the first post-reset cycle, fifo_level=0.
- Preload RAM[0x0010]=0x123456. vid_req pulsed at cycle 10 with vid_adr=0x0010 → vid_valid=1 and vid_q=0x123456 at cycle 12 only.
- vid_req held high for 8 cycles while the host pushes 5 writes, DEPTH=4 → 4 accepted and host_ready=0 with fifo_level=4. Zero ram_we during the video burst. Writes drain one per cycle after vid_req drops, in order, and host_ready returns.
- Alternating vid_req (1,0,1,0…) plus a queued host write to 0x0005 with data 0xABCDEF → the write is issued in the first free slot, and a subsequent video read of 0x0005 returns 0xABCDEF.
- With FB_ARB_HOST_READ_EN defined: host write 0x0007←0x00FF00, then a host read of 0x0007 → host_rvalid with host_q=0x00FF00. Without the macro, the same read → no host_rvalid, and fifo_level does not increment for the read.
- reset asserted with 3 FIFO entries and a video read in flight → no vid_valid, no further ram_we, fifo_level=0 after the reset cycle.
